// File: rtl/reg_file.sv
// reg_file: 32 x 64-bit register file, two combinational read ports and one
// synchronous write port. Register ZERO_REG (31) always reads zero and
// ignores writes. write_count tracks committed writes, saturating at 255.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_reg_a,
    input  logic [4:0]            read_reg_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic [7:0]            write_count
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   write_onehot;
    logic                  write_commit;
    logic [DATA_WIDTH-1:0] tree_a;
    logic [DATA_WIDTH-1:0] tree_b;

    // Eight-way mux followed by a four-way mux. The low select bits pick
    // within a group of eight and the high bits pick the group, so select k
    // always lands on register k.
    function automatic logic [DATA_WIDTH-1:0] read_tree(input logic [4:0] sel);
        logic [DATA_WIDTH-1:0] group_out [4];
        for (int unsigned g = 0; g < 4; g++) begin
            group_out[g] = regs[{2'(g), sel[2:0]}];
        end
        if (sel == 5'(ZERO_REG)) begin
            return '0;
        end
        return group_out[sel[4:3]];
    endfunction

    // One-hot write decode gated by write_enable; the zero register never loads.
    always_comb begin
        write_onehot = '0;
        if (write_enable && (write_reg != 5'(ZERO_REG))) begin
            write_onehot[write_reg] = 1'b1;
        end
        write_commit = |write_onehot;
    end

    // Register storage: reset clears everything and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (write_onehot[i]) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    // Committed-write counter, holding at 255 instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_count <= '0;
        end else if (write_commit && (write_count != 8'hFF)) begin
            write_count <= write_count + 8'd1;
        end
    end

    // Read trees for both ports.
    always_comb begin
        tree_a = read_tree(read_reg_a);
        tree_b = read_tree(read_reg_b);
    end

`ifdef REG_FILE_BYPASS_EN
    // Write-through forwarding: a 2:1 select after each tree, disabled in reset.
    always_comb begin
        read_data_a = tree_a;
        read_data_b = tree_b;
        if (reset_n && write_commit) begin
            if (read_reg_a == write_reg) read_data_a = write_data;
            if (read_reg_b == write_reg) read_data_b = write_data;
        end
    end
`else
    // No forwarding: reads always reflect stored state.
    always_comb begin
        read_data_a = tree_a;
        read_data_b = tree_b;
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [4:0]  read_reg_a;
    logic [4:0]  read_reg_b;
    logic [63:0] read_data_a;
    logic [63:0] read_data_b;
    logic [7:0]  write_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] STRIDE = 64'h0101_0101_0101_0101;

    reg_file #(
        .DATA_WIDTH (64),
        .NUM_REGS   (32),
        .ZERO_REG   (31)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_reg_a   (read_reg_a),
        .read_reg_b   (read_reg_b),
        .read_data_a  (read_data_a),
        .read_data_b  (read_data_b),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] r, input logic [63:0] d);
        write_enable = 1'b1;
        write_reg    = r;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b1;
        write_enable = 1'b0;
        write_reg    = '0;
        write_data   = '0;
        read_reg_a   = '0;
        read_reg_b   = '0;

        // Reset after a prior write
        write(5'd5, 64'hDEAD);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            read_reg_a = 5'(k);
            #1;
            check($sformatf("reset_rd_x%0d", k), read_data_a, 64'h0);
        end
        check("reset_count", {56'h0, write_count}, 64'd0);

        // Write every writable register, then sweep both ports
        for (int k = 0; k < 31; k++) begin
            write(5'(k), 64'(k) * STRIDE);
        end
        for (int k = 0; k < 31; k++) begin
            read_reg_a = 5'(k);
            read_reg_b = 5'(30 - k);
            #1;
            check($sformatf("sweep_a_x%0d", k), read_data_a, 64'(k) * STRIDE);
            check($sformatf("sweep_b_x%0d", 30 - k), read_data_b, 64'(30 - k) * STRIDE);
        end
        read_reg_a = 5'd12;
        read_reg_b = 5'd12;
        #1;
        check("same_idx_a", read_data_a, 64'd12 * STRIDE);
        check("same_idx_b", read_data_b, 64'd12 * STRIDE);
        check("count_after_sweep", {56'h0, write_count}, 64'd31);

        // Zero register ignores writes and does not count
        write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        read_reg_a = 5'd31;
        read_reg_b = 5'd30;
        #1;
        check("xzr_read", read_data_a, 64'h0);
        check("x30_intact", read_data_b, 64'd30 * STRIDE);
        check("xzr_count", {56'h0, write_count}, 64'd31);

        // Same-cycle read of the register being written
        write(5'd7, 64'h11);
        read_reg_a   = 5'd7;
        write_enable = 1'b1;
        write_reg    = 5'd7;
        write_data   = 64'h22;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("hazard_same_cycle", read_data_a, 64'h22);
`else
        check("hazard_same_cycle", read_data_a, 64'h11);
`endif
        tick();
        write_enable = 1'b0;
        #1;
        check("hazard_next_cycle", read_data_a, 64'h22);
        check("hazard_count", {56'h0, write_count}, 64'd33);

        // Idle cycle with junk on the write bus must not change anything
        write_reg  = 5'd9;
        write_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        read_reg_a = 5'd9;
        #1;
        check("idle_no_write", read_data_a, 64'd9 * STRIDE);
        check("idle_count", {56'h0, write_count}, 64'd33);

        // Reset beats a simultaneous write
        reset_n      = 1'b0;
        write_enable = 1'b1;
        write_reg    = 5'd3;
        write_data   = 64'h55;
        tick();
        reset_n      = 1'b0;
        write_enable = 1'b0;
        reset_n      = 1'b1;
        read_reg_a   = 5'd3;
        read_reg_b   = 5'd7;
        #1;
        check("rst_vs_wr_x3", read_data_a, 64'h0);
        check("rst_vs_wr_x7", read_data_b, 64'h0);
        check("rst_vs_wr_count", {56'h0, write_count}, 64'd0);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            write(5'd1, 64'(i) + 64'h1000);
            if (i == 253) check("count_254", {56'h0, write_count}, 64'd254);
            if (i == 254) check("count_255", {56'h0, write_count}, 64'd255);
        end
        read_reg_a = 5'd1;
        #1;
        check("sat_count", {56'h0, write_count}, 64'd255);
        check("sat_x1_last", read_data_a, 64'd299 + 64'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
